// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode stage: opcodes, functs, ALU ops and field widths.
package mips_pkg;

    localparam int INSTR_W  = 32;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 32;
    localparam int SHAMT_W  = 5;
    localparam int ALU_OP_W = 3;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_LUI = 3'd7
    } alu_op_e;

    function automatic logic [IMM_W-1:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [IMM_W-1:0] zero_ext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational instruction decoder: controls, destination, immediate and operand usage.
module id_decoder
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0]  instr,
    output logic [REG_W-1:0]    dst,
    output logic [IMM_W-1:0]    imm,
    output logic [SHAMT_W-1:0]  shamt,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                branch,
    output logic                uses_rs,
    output logic                uses_rt,
    output logic                illegal
);

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [15:0]      imm16;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             writes;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];

    // Writes to $0 are dropped here so EX/WB never see a live write to the zero register.
    assign reg_write = writes && (dst != '0);

    // Opcode/funct decode; every output defaults to the bubble value.
    always_comb begin
        dst       = '0;
        imm       = '0;
        shamt     = '0;
        alu_op    = ALU_ADD;
        alu_src   = 1'b0;
        writes    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        uses_rs   = 1'b0;
        uses_rt   = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dst     = rd;
                shamt   = instr[10:6];
                writes  = 1'b1;
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                case (funct)
                    FN_ADD: alu_op = ALU_ADD;
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_SLT: alu_op = ALU_SLT;
                    FN_SLL: begin
                        alu_op  = ALU_SLL;
                        uses_rs = 1'b0;
                    end
                    FN_SRL: begin
                        alu_op  = ALU_SRL;
                        uses_rs = 1'b0;
                    end
                    default: begin
                        illegal = 1'b1;
                        writes  = 1'b0;
                        dst     = '0;
                        uses_rs = 1'b0;
                        uses_rt = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                dst     = rt;
                imm     = sign_ext16(imm16);
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
                writes  = 1'b1;
                uses_rs = 1'b1;
            end
            OP_ANDI: begin
                dst     = rt;
                imm     = zero_ext16(imm16);
                alu_op  = ALU_AND;
                alu_src = 1'b1;
                writes  = 1'b1;
                uses_rs = 1'b1;
            end
            OP_ORI: begin
                dst     = rt;
                imm     = zero_ext16(imm16);
                alu_op  = ALU_OR;
                alu_src = 1'b1;
                writes  = 1'b1;
                uses_rs = 1'b1;
            end
            OP_LUI: begin
                dst     = rt;
                imm     = {imm16, 16'h0000};
                alu_op  = ALU_LUI;
                alu_src = 1'b1;
                writes  = 1'b1;
            end
            OP_LW: begin
                dst      = rt;
                imm      = sign_ext16(imm16);
                alu_op   = ALU_ADD;
                alu_src  = 1'b1;
                writes   = 1'b1;
                mem_read = 1'b1;
                uses_rs  = 1'b1;
            end
            OP_SW: begin
                imm       = sign_ext16(imm16);
                alu_op    = ALU_ADD;
                alu_src   = 1'b1;
                mem_write = 1'b1;
                uses_rs   = 1'b1;
                uses_rt   = 1'b1;
            end
            OP_BEQ: begin
                imm     = sign_ext16(imm16);
                alu_op  = ALU_SUB;
                branch  = 1'b1;
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// ID stage: regFile read addressing, WB bypass, load-use hazard detection and the ID/EX register.
module id_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [31:0]       i_instr,
    input  logic              i_valid,
    input  logic              i_flush,
    output logic [RA_W-1:0]   o_raddr1,
    output logic [RA_W-1:0]   o_raddr2,
    input  logic [DATA_W-1:0] i_rdata1,
    input  logic [DATA_W-1:0] i_rdata2,
    input  logic              i_wb_we,
    input  logic [RA_W-1:0]   i_wb_waddr,
    input  logic [DATA_W-1:0] i_wb_wdata,
    output logic              o_stall,
    output logic              o_illegal,
    output logic              o_ex_valid,
    output logic [DATA_W-1:0] o_ex_rs_data,
    output logic [DATA_W-1:0] o_ex_rt_data,
    output logic [DATA_W-1:0] o_ex_imm,
    output logic [4:0]        o_ex_shamt,
    output logic [RA_W-1:0]   o_ex_rs,
    output logic [RA_W-1:0]   o_ex_rt,
    output logic [RA_W-1:0]   o_ex_dst,
    output logic [2:0]        o_ex_alu_op,
    output logic              o_ex_alu_src,
    output logic              o_ex_reg_write,
    output logic              o_ex_mem_read,
    output logic              o_ex_mem_write,
    output logic              o_ex_branch
);

    logic [RA_W-1:0]     dec_dst;
    logic [DATA_W-1:0]   dec_imm;
    logic [4:0]          dec_shamt;
    logic [2:0]          dec_alu_op;
    logic                dec_alu_src;
    logic                dec_reg_write;
    logic                dec_mem_read;
    logic                dec_mem_write;
    logic                dec_branch;
    logic                dec_uses_rs;
    logic                dec_uses_rt;
    logic                dec_illegal;
    logic [DATA_W-1:0]   rs_val;
    logic [DATA_W-1:0]   rt_val;
    logic                hazard;
    logic                bubble;

    id_decoder u_dec (
        .instr     (i_instr),
        .dst       (dec_dst),
        .imm       (dec_imm),
        .shamt     (dec_shamt),
        .alu_op    (dec_alu_op),
        .alu_src   (dec_alu_src),
        .reg_write (dec_reg_write),
        .mem_read  (dec_mem_read),
        .mem_write (dec_mem_write),
        .branch    (dec_branch),
        .uses_rs   (dec_uses_rs),
        .uses_rt   (dec_uses_rt),
        .illegal   (dec_illegal)
    );

    assign o_raddr1 = i_instr[25:21];
    assign o_raddr2 = i_instr[20:16];

    // Operand fetch: $0 is hard zero, otherwise a same-cycle WB write wins over the array read.
    always_comb begin
        rs_val = i_rdata1;
        rt_val = i_rdata2;
        if (o_raddr1 == '0)
            rs_val = '0;
        else if (i_wb_we && (i_wb_waddr == o_raddr1))
            rs_val = i_wb_wdata;
        if (o_raddr2 == '0)
            rt_val = '0;
        else if (i_wb_we && (i_wb_waddr == o_raddr2))
            rt_val = i_wb_wdata;
    end

    // A load in EX cannot forward in time; any consumer of its destination must wait a cycle.
    assign hazard = o_ex_valid && o_ex_mem_read && (o_ex_dst != '0) &&
                    ((dec_uses_rs && (o_raddr1 == o_ex_dst)) ||
                     (dec_uses_rt && (o_raddr2 == o_ex_dst)));

    assign o_stall   = hazard && i_valid && !i_flush && !i_rst;
    assign o_illegal = i_valid && dec_illegal && !i_rst;
    assign bubble    = i_rst || i_flush || hazard || !i_valid || dec_illegal;

    // ID/EX pipeline register: load a bubble or the freshly decoded instruction.
    always_ff @(posedge i_clk) begin
        if (bubble) begin
            o_ex_valid     <= 1'b0;
            o_ex_rs_data   <= '0;
            o_ex_rt_data   <= '0;
            o_ex_imm       <= '0;
            o_ex_shamt     <= '0;
            o_ex_rs        <= '0;
            o_ex_rt        <= '0;
            o_ex_dst       <= '0;
            o_ex_alu_op    <= '0;
            o_ex_alu_src   <= 1'b0;
            o_ex_reg_write <= 1'b0;
            o_ex_mem_read  <= 1'b0;
            o_ex_mem_write <= 1'b0;
            o_ex_branch    <= 1'b0;
        end else begin
            o_ex_valid     <= 1'b1;
            o_ex_rs_data   <= rs_val;
            o_ex_rt_data   <= rt_val;
            o_ex_imm       <= dec_imm;
            o_ex_shamt     <= dec_shamt;
            o_ex_rs        <= o_raddr1;
            o_ex_rt        <= o_raddr2;
            o_ex_dst       <= dec_dst;
            o_ex_alu_op    <= dec_alu_op;
            o_ex_alu_src   <= dec_alu_src;
            o_ex_reg_write <= dec_reg_write;
            o_ex_mem_read  <= dec_mem_read;
            o_ex_mem_write <= dec_mem_write;
            o_ex_branch    <= dec_branch;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: driver pushes expected ID/EX contents, monitor pops after each edge.
module tb_id_stage;

    localparam int DATA_W = 32;
    localparam int RA_W   = 5;

    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
    } exp_t;

    localparam exp_t BUB = '0;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [31:0]       i_instr;
    logic              i_valid;
    logic              i_flush;
    logic [RA_W-1:0]   o_raddr1, o_raddr2;
    logic [DATA_W-1:0] i_rdata1, i_rdata2;
    logic              i_wb_we;
    logic [RA_W-1:0]   i_wb_waddr;
    logic [DATA_W-1:0] i_wb_wdata;
    logic              o_stall, o_illegal;
    logic              o_ex_valid;
    logic [DATA_W-1:0] o_ex_rs_data, o_ex_rt_data, o_ex_imm;
    logic [4:0]        o_ex_shamt;
    logic [RA_W-1:0]   o_ex_rs, o_ex_rt, o_ex_dst;
    logic [2:0]        o_ex_alu_op;
    logic              o_ex_alu_src, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_branch;

    int n_vec = 0;
    int n_err = 0;
    exp_t  exp_q[$];
    string name_q[$];

    id_stage #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr), .i_valid(i_valid), .i_flush(i_flush),
        .o_raddr1(o_raddr1), .o_raddr2(o_raddr2), .i_rdata1(i_rdata1), .i_rdata2(i_rdata2),
        .i_wb_we(i_wb_we), .i_wb_waddr(i_wb_waddr), .i_wb_wdata(i_wb_wdata),
        .o_stall(o_stall), .o_illegal(o_illegal),
        .o_ex_valid(o_ex_valid), .o_ex_rs_data(o_ex_rs_data), .o_ex_rt_data(o_ex_rt_data),
        .o_ex_imm(o_ex_imm), .o_ex_shamt(o_ex_shamt), .o_ex_rs(o_ex_rs), .o_ex_rt(o_ex_rt),
        .o_ex_dst(o_ex_dst), .o_ex_alu_op(o_ex_alu_op), .o_ex_alu_src(o_ex_alu_src),
        .o_ex_reg_write(o_ex_reg_write), .o_ex_mem_read(o_ex_mem_read),
        .o_ex_mem_write(o_ex_mem_write), .o_ex_branch(o_ex_branch)
    );

    always #5 i_clk = ~i_clk;

    function automatic exp_t mk(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                                input logic [31:0] im, input logic [4:0] sh, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] dst, input logic [2:0] op,
                                input logic src, input logic rw, input logic mr, input logic mw,
                                input logic br);
        exp_t e;
        e.valid = v;       e.rs_data = rsd;  e.rt_data = rtd;  e.imm = im;
        e.shamt = sh;      e.rs = rs;        e.rt = rt;        e.dst = dst;
        e.alu_op = op;     e.alu_src = src;  e.reg_write = rw;
        e.mem_read = mr;   e.mem_write = mw; e.branch = br;
        return e;
    endfunction

    task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got %h, expected %h", nm, what, act, req);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic fl, input logic rst,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge i_clk);
        i_instr = ins;   i_valid = v;     i_flush = fl;   i_rst = rst;
        i_rdata1 = rd1;  i_rdata2 = rd2;
        i_wb_we = we;    i_wb_waddr = wa; i_wb_wdata = wd;
    endtask

    // Check the combinational outputs for the vector and queue the ID/EX contents due after the edge.
    task automatic step(input string nm, input exp_t e, input logic st, input logic il);
        logic [31:0] ins;
        #1;
        ins = i_instr;
        chk(nm, "stall", {31'd0, o_stall}, {31'd0, st});
        chk(nm, "illegal", {31'd0, o_illegal}, {31'd0, il});
        chk(nm, "raddr1", {27'd0, o_raddr1}, {27'd0, ins[25:21]});
        chk(nm, "raddr2", {27'd0, o_raddr2}, {27'd0, ins[20:16]});
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: after every rising edge compare the ID/EX register against the oldest expectation.
    always @(posedge i_clk) begin
        exp_t  e;
        exp_t  a;
        string nm;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {o_ex_valid, o_ex_rs_data, o_ex_rt_data, o_ex_imm, o_ex_shamt, o_ex_rs, o_ex_rt,
                  o_ex_dst, o_ex_alu_op, o_ex_alu_src, o_ex_reg_write, o_ex_mem_read,
                  o_ex_mem_write, o_ex_branch};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s.idex: got %h, expected %h", nm, a, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] ADD_321 = 32'h00221820;
    localparam logic [31:0] LW_4    = 32'h8C240008;
    localparam logic [31:0] ADD_544 = 32'h00842820;

    initial begin
        i_rst = 1'b1; i_instr = '0; i_valid = 1'b0; i_flush = 1'b0;
        i_rdata1 = '0; i_rdata2 = '0; i_wb_we = 1'b0; i_wb_waddr = '0; i_wb_wdata = '0;

        drive(ADD_321, 1, 0, 1, 5, 7, 0, 0, 0);
        step("reset", BUB, 0, 0);
        drive(ADD_321, 1, 0, 0, 5, 7, 0, 0, 0);
        step("add", mk(1, 5, 7, 0, 0, 1, 2, 3, 3'd0, 0, 1, 0, 0, 0), 0, 0);
        drive(ADD_321, 1, 0, 0, 5, 7, 1, 2, 32'h99);
        step("byp_rt", mk(1, 5, 32'h99, 0, 0, 1, 2, 3, 3'd0, 0, 1, 0, 0, 0), 0, 0);
        drive(ADD_321, 1, 0, 0, 5, 7, 1, 0, 32'h99);
        step("byp_r0", mk(1, 5, 7, 0, 0, 1, 2, 3, 3'd0, 0, 1, 0, 0, 0), 0, 0);
        drive(ADD_321, 1, 0, 0, 5, 7, 1, 1, 32'h42);
        step("byp_rs", mk(1, 32'h42, 7, 0, 0, 1, 2, 3, 3'd0, 0, 1, 0, 0, 0), 0, 0);
        drive(ADD_321, 0, 0, 0, 5, 7, 0, 0, 0);
        step("invalid", BUB, 0, 0);

        drive(LW_4, 1, 0, 0, 32'h100, 32'h55, 0, 0, 0);
        step("lw", mk(1, 32'h100, 32'h55, 8, 0, 1, 4, 4, 3'd0, 1, 1, 1, 0, 0), 0, 0);
        drive(ADD_544, 1, 0, 0, 1, 1, 0, 0, 0);
        step("lu_stall", BUB, 1, 0);
        drive(ADD_544, 1, 0, 0, 1, 1, 1, 4, 32'hABC);
        step("lu_issue", mk(1, 32'hABC, 32'hABC, 0, 0, 4, 4, 5, 3'd0, 0, 1, 0, 0, 0), 0, 0);

        drive(LW_4, 1, 0, 0, 32'h100, 32'h55, 0, 0, 0);
        step("lw2", mk(1, 32'h100, 32'h55, 8, 0, 1, 4, 4, 3'd0, 1, 1, 1, 0, 0), 0, 0);
        drive(32'h3C861234, 1, 0, 0, 32'h11, 32'h22, 0, 0, 0);
        step("lui_nostall", mk(1, 32'h11, 32'h22, 32'h12340000, 0, 4, 6, 6, 3'd7, 1, 1, 0, 0, 0), 0, 0);

        drive(LW_4, 1, 0, 0, 32'h100, 32'h55, 0, 0, 0);
        step("lw3", mk(1, 32'h100, 32'h55, 8, 0, 1, 4, 4, 3'd0, 1, 1, 1, 0, 0), 0, 0);
        drive(ADD_544, 1, 1, 0, 1, 1, 0, 0, 0);
        step("flush_haz", BUB, 0, 0);

        drive(32'h2027FFFF, 1, 0, 0, 3, 0, 0, 0, 0);
        step("addi", mk(1, 3, 0, 32'hFFFFFFFF, 0, 1, 7, 7, 3'd0, 1, 1, 0, 0, 0), 0, 0);
        drive(32'h3428FFFF, 1, 0, 0, 3, 0, 0, 0, 0);
        step("ori", mk(1, 3, 0, 32'h0000FFFF, 0, 1, 8, 8, 3'd3, 1, 1, 0, 0, 0), 0, 0);
        drive(32'hFC000000, 1, 0, 0, 0, 0, 0, 0, 0);
        step("ill_op", BUB, 0, 1);
        drive(32'h00221821, 1, 0, 0, 5, 7, 0, 0, 0);
        step("ill_fn", BUB, 0, 1);
        drive(32'h20200005, 1, 0, 0, 9, 32'h77, 0, 0, 0);
        step("addi_r0", mk(1, 9, 0, 5, 0, 1, 0, 0, 3'd0, 1, 0, 0, 0, 0), 0, 0);
        drive(32'hAC220004, 1, 0, 0, 32'h10, 32'h20, 0, 0, 0);
        step("sw", mk(1, 32'h10, 32'h20, 4, 0, 1, 2, 0, 3'd0, 1, 0, 0, 1, 0), 0, 0);
        drive(32'h1022FFFF, 1, 0, 0, 1, 2, 0, 0, 0);
        step("beq", mk(1, 1, 2, 32'hFFFFFFFF, 0, 1, 2, 0, 3'd1, 0, 0, 0, 0, 1), 0, 0);
        drive(32'h00021900, 1, 0, 0, 32'hDEAD, 8, 0, 0, 0);
        step("sll", mk(1, 0, 8, 0, 4, 0, 2, 3, 3'd5, 0, 1, 0, 0, 0), 0, 0);
        drive(32'h00021842, 1, 0, 0, 0, 8, 0, 0, 0);
        step("srl", mk(1, 0, 8, 0, 1, 0, 2, 3, 3'd6, 0, 1, 0, 0, 0), 0, 0);
        drive(32'h00221822, 1, 0, 0, 10, 4, 0, 0, 0);
        step("sub", mk(1, 10, 4, 0, 0, 1, 2, 3, 3'd1, 0, 1, 0, 0, 0), 0, 0);
        drive(32'h0022182A, 1, 0, 0, 10, 4, 0, 0, 0);
        step("slt", mk(1, 10, 4, 0, 0, 1, 2, 3, 3'd4, 0, 1, 0, 0, 0), 0, 0);

        drive(LW_4, 1, 0, 0, 32'h100, 32'h55, 0, 0, 0);
        step("lw4", mk(1, 32'h100, 32'h55, 8, 0, 1, 4, 4, 3'd0, 1, 1, 1, 0, 0), 0, 0);
        drive(32'hAC240000, 1, 0, 0, 32'h10, 32'h20, 0, 0, 0);
        step("sw_rt_stall", BUB, 1, 0);
        drive(32'hAC240000, 1, 0, 0, 32'h10, 32'h20, 0, 0, 0);
        step("sw_issue", mk(1, 32'h10, 32'h20, 0, 0, 1, 4, 0, 3'd0, 1, 0, 0, 1, 0), 0, 0);

        drive(LW_4, 1, 0, 0, 32'h100, 32'h55, 0, 0, 0);
        step("lw5", mk(1, 32'h100, 32'h55, 8, 0, 1, 4, 4, 3'd0, 1, 1, 1, 0, 0), 0, 0);
        drive(ADD_544, 1, 0, 1, 1, 1, 0, 0, 0);
        step("rst_in_stall", BUB, 0, 0);
        drive(ADD_544, 1, 0, 0, 1, 1, 0, 0, 0);
        step("after_rst", mk(1, 1, 1, 0, 0, 4, 4, 5, 3'd0, 0, 1, 0, 0, 0), 0, 0);

        drive(32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge i_clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
